dram_slot_sched: RTL and testbench
==================================

// Module: dram_slot_sched
// PURPOSE
//  Slot scheduler for the shared DRAM controller; sits between the requesters (video fetch, Z80 memory, DMA) and dram.
//  Once per DRAM cycle it picks an owner (forced refresh, video, CPU, DMA, opportunistic refresh, or idle).
//  It registers that owner's request onto the dram port and returns read data to the owner via a tag queue.
// PARAMETERS
//  AW            21   DRAM word-address width
//  REFRESH_SLOTS 64   slots between refresh-credit increments
//  RFSH_MAX      4    refresh-credit saturation; at this value refresh is forced
//  RDQ_DEPTH     2    outstanding-read tag queue depth
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   synchronous reset, active-high
//  slot         in   1   pulse one clk before dram cbeg; decision edge
//  rrdy         in   1   dram read data valid
//  rddata       in   16  dram read data
//  dram_req     out  1   access request, sampled by dram at cbeg
//  dram_rnw     out  1   1=read 0=write
//  dram_addr    out  AW  word address
//  dram_bsel    out  2   byte enables {hi,lo}
//  dram_wrdata  out  16  write data
//  dram_rfsh    out  1   refresh cycle request (dram_req=0)
//  video_go     in   1   video fetch enabled
//  video_bw     in   2   video bandwidth code
//  video_addr   in   AW  video read address
//  video_next   out  1   video slot granted, 1 clk
//  video_strobe out  1   video read data valid on rd_data
//  cpu_req      in   1   CPU access pending
//  cpu_rnw      in   1   CPU read/write
//  cpu_addr     in   AW  CPU word address
//  cpu_wrbsel   in   1   CPU write byte: 0=lo 1=hi
//  cpu_wrdata   in   8   CPU write byte
//  cpu_next     out  1   CPU slot granted, 1 clk
//  cpu_strobe   out  1   CPU read data valid
//  cpu_stall    out  1   cpu_req & ~cpu_next (combinational)
//  dma_req, dma_rnw, dma_addr[AW], dma_bsel[2], dma_wrdata[16]  in   DMA request, same meaning
//  dma_next, dma_strobe  out  1   DMA grant / read data valid
//  rd_data      out  16  registered read data, shared by all strobes
//  sched_err    out  1   sticky: rrdy received with empty tag queue
// BEHAVIOUR
//  - Reset: all outputs 0, slot_cnt=0, refresh counter 0, credit 0, tag queue empty, sched_err=0.
//  - All decisions are made on the clk edge where slot=1. dram_* outputs are registered and held until the next slot edge.
//    The winner's *_next is high for exactly that clk.
//  - slot_cnt: 3 bits, increments every slot, wraps 7->0.
//  - Video mask (video_go=1): bw=00 slot 0; 01 slots 0,4; 10 even slots; 11 all slots. video_go=0: no video slots.
//  - Refresh: counter increments per slot. At REFRESH_SLOTS-1 it wraps and credit++ (saturates at RFSH_MAX).
//    Increment and issue in the same slot leave credit unchanged.
//  - Priority: credit==RFSH_MAX refresh > video (masked slot) > CPU > DMA > credit>0 refresh > idle.
//  - A read owner is eligible only if the tag queue is not full. Writes and refresh are always eligible.
//    A blocked video read makes its slot fall through to lower priorities.
//  - Issue encoding:
//    video: req=1, rnw=1, bsel=11.
//    cpu write: bsel = wrbsel ? 10 : 01; wrdata = {cpu_wrdata,cpu_wrdata}.
//    cpu read: bsel=11.
//    refresh: req=0, rfsh=1, credit--.
//    idle: req=0, rfsh=0.
//  - Tag queue: the owner tag is pushed on each issued read and popped on rrdy. Simultaneous push and pop is legal.
//    The clk after rrdy: rd_data<=rddata and the popped owner's strobe pulses for 1 clk.
//  - rrdy with an empty queue: discarded, sched_err<=1 (held until rst). dram shares rst, so no stray rrdy after reset.
//  - Reset mid-cycle: drops in-flight tags and any pending grant; the dram request returns to idle on the next clk.
// STRUCTURE
//  - dram_slot_sched_pkg: owner enum (OWN_IDLE, OWN_RFSH, OWN_VID, OWN_CPU, OWN_DMA), 2-bit tag type,
//    function vid_mask(bw, slot_cnt).
//  - Sub-module dram_tag_fifo (RDQ_DEPTH x tag, push/pop/full/empty). The priority mux and counters stay in the top level.
// TESTING
//  1. rst held 3 clks mid-traffic -> next clk all outputs 0, credit 0; the first slot after rst goes to a waiting cpu_req.
//  2. video_go=1, bw=01, CPU and DMA reading continuously -> video_next in slots 0,4.
//     CPU wins the other 6, DMA 0; strobes return in issue order.
//  3. cpu write, wrbsel=1, data 0xA5 -> dram_bsel=10, wrdata=0xA5A5, rnw=0, cpu_stall drops the same clk as cpu_next.
//  4. REFRESH_SLOTS=4, bw=11 -> credit reaches 4 after 16 slots. The refresh preempts video, then credit=3.
//  5. Two reads outstanding, no rrdy -> third read blocked, video slot passes to a pending write.
//     rrdy+issue in the same clk -> queue count unchanged.
//  6. rrdy pulse with queue empty -> sched_err=1; it stays 1 through traffic until rst.

Source files
------------

// File: rtl/dram_slot_sched_pkg.sv
// Shared types and helpers for the DRAM slot scheduler: owner codes,
// read-return tag codes and the video slot mask.
package dram_slot_sched_pkg;

    typedef enum logic [2:0] {
        OWN_IDLE = 3'd0,
        OWN_RFSH = 3'd1,
        OWN_VID  = 3'd2,
        OWN_CPU  = 3'd3,
        OWN_DMA  = 3'd4
    } owner_e;

    typedef logic [1:0] tag_t;

    localparam tag_t TAG_VID  = 2'd0;
    localparam tag_t TAG_CPU  = 2'd1;
    localparam tag_t TAG_DMA  = 2'd2;
    localparam tag_t TAG_NONE = 2'd3;

    // Video owns slot 0 only, slots 0/4, even slots, or every slot.
    function automatic logic vid_mask(input logic [1:0] bw, input logic [2:0] slot_cnt);
        logic hit;
        case (bw)
            2'b00:   hit = (slot_cnt == 3'd0);
            2'b01:   hit = (slot_cnt[1:0] == 2'd0);
            2'b10:   hit = ~slot_cnt[0];
            2'b11:   hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/dram_tag_fifo.sv
// Small FIFO of owner tags for reads issued to DRAM and not yet returned.
// Push on read issue, pop on read data return; both may happen together.
module dram_tag_fifo
    import dram_slot_sched_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  tag_t i_push_tag,
    input  logic i_pop,
    output tag_t o_pop_tag,
    output logic o_full,
    output logic o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    tag_t          r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & ~o_full;
    assign o_pop_tag = r_mem[r_rptr];

    // Tag storage; cleared on reset so stale tags can never be popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= TAG_NONE;
            end
        end else if (w_do_push) begin
            r_mem[r_wptr] <= i_push_tag;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wptr <= ptr_next(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dram_slot_sched.sv
// DRAM slot scheduler. On every slot pulse it picks one owner (forced
// refresh, video, CPU, DMA, opportunistic refresh or idle), registers that
// owner's access onto the dram port, and routes returned read data back to
// the issuing owner using a tag FIFO.
module dram_slot_sched
    import dram_slot_sched_pkg::*;
#(
    parameter int AW            = 21,
    parameter int REFRESH_SLOTS = 64,
    parameter int RFSH_MAX      = 4,
    parameter int RDQ_DEPTH     = 2
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          slot,
    input  logic          rrdy,
    input  logic [15:0]   rddata,
    output logic          dram_req,
    output logic          dram_rnw,
    output logic [AW-1:0] dram_addr,
    output logic [1:0]    dram_bsel,
    output logic [15:0]   dram_wrdata,
    output logic          dram_rfsh,
    input  logic          video_go,
    input  logic [1:0]    video_bw,
    input  logic [AW-1:0] video_addr,
    output logic          video_next,
    output logic          video_strobe,
    input  logic          cpu_req,
    input  logic          cpu_rnw,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_wrbsel,
    input  logic [7:0]    cpu_wrdata,
    output logic          cpu_next,
    output logic          cpu_strobe,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_rnw,
    input  logic [AW-1:0] dma_addr,
    input  logic [1:0]    dma_bsel,
    input  logic [15:0]   dma_wrdata,
    output logic          dma_next,
    output logic          dma_strobe,
    output logic [15:0]   rd_data,
    output logic          sched_err
);

    localparam int RC_W = (REFRESH_SLOTS > 1) ? $clog2(REFRESH_SLOTS) : 1;
    localparam int CR_W = $clog2(RFSH_MAX + 1);

    logic [2:0]      r_slot_cnt;
    logic [RC_W-1:0] r_rfsh_cnt;
    logic [CR_W-1:0] r_credit;

    logic            r_dram_req;
    logic            r_dram_rnw;
    logic [AW-1:0]   r_dram_addr;
    logic [1:0]      r_dram_bsel;
    logic [15:0]     r_dram_wrdata;
    logic            r_dram_rfsh;
    logic            r_video_next;
    logic            r_cpu_next;
    logic            r_dma_next;
    logic            r_video_strobe;
    logic            r_cpu_strobe;
    logic            r_dma_strobe;
    logic [15:0]     r_rd_data;
    logic            r_sched_err;

    owner_e          w_owner;
    tag_t            w_push_tag;
    tag_t            w_pop_tag;
    logic            w_push;
    logic            w_pop;
    logic            w_q_full;
    logic            w_q_empty;
    logic            w_credit_max;
    logic            w_credit_any;
    logic            w_vid_ok;
    logic            w_cpu_ok;
    logic            w_dma_ok;
    logic            w_rfsh_wrap;
    logic            w_rfsh_issue;

    // A read can only be granted while there is room to remember its owner.
    assign w_credit_max = (r_credit == CR_W'(RFSH_MAX));
    assign w_credit_any = (r_credit != {CR_W{1'b0}});
    assign w_vid_ok     = video_go & vid_mask(video_bw, r_slot_cnt) & ~w_q_full;
    assign w_cpu_ok     = cpu_req & (~cpu_rnw | ~w_q_full);
    assign w_dma_ok     = dma_req & (~dma_rnw | ~w_q_full);
    assign w_rfsh_wrap  = slot & (r_rfsh_cnt == RC_W'(REFRESH_SLOTS - 1));
    assign w_rfsh_issue = slot & (w_owner == OWN_RFSH);
    assign w_pop        = rrdy & ~w_q_empty;

    // Owner priority for the coming DRAM cycle.
    always_comb begin
        w_owner = OWN_IDLE;
        if (w_credit_max) begin
            w_owner = OWN_RFSH;
        end else if (w_vid_ok) begin
            w_owner = OWN_VID;
        end else if (w_cpu_ok) begin
            w_owner = OWN_CPU;
        end else if (w_dma_ok) begin
            w_owner = OWN_DMA;
        end else if (w_credit_any) begin
            w_owner = OWN_RFSH;
        end else begin
            w_owner = OWN_IDLE;
        end
    end

    // Tag to queue when the chosen owner performs a read.
    always_comb begin
        w_push     = 1'b0;
        w_push_tag = TAG_NONE;
        case (w_owner)
            OWN_VID: begin
                w_push     = slot;
                w_push_tag = TAG_VID;
            end
            OWN_CPU: begin
                w_push     = slot & cpu_rnw;
                w_push_tag = TAG_CPU;
            end
            OWN_DMA: begin
                w_push     = slot & dma_rnw;
                w_push_tag = TAG_DMA;
            end
            default: begin
                w_push     = 1'b0;
                w_push_tag = TAG_NONE;
            end
        endcase
    end

    dram_tag_fifo #(
        .DEPTH      (RDQ_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_tag (w_push_tag),
        .i_pop      (w_pop),
        .o_pop_tag  (w_pop_tag),
        .o_full     (w_q_full),
        .o_empty    (w_q_empty)
    );

    // Slot position and refresh interval counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_cnt <= 3'd0;
            r_rfsh_cnt <= {RC_W{1'b0}};
        end else if (slot) begin
            r_slot_cnt <= r_slot_cnt + 3'd1;
            r_rfsh_cnt <= w_rfsh_wrap ? {RC_W{1'b0}} : r_rfsh_cnt + RC_W'(1);
        end
    end

    // Refresh credit: earned at each interval wrap, spent by each refresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= {CR_W{1'b0}};
        end else begin
            case ({w_rfsh_wrap, w_rfsh_issue})
                2'b10: begin
                    if (!w_credit_max) begin
                        r_credit <= r_credit + CR_W'(1);
                    end
                end
                2'b01:   r_credit <= r_credit - CR_W'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    // Register the winner's access onto the dram port; held between slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dram_req    <= 1'b0;
            r_dram_rnw    <= 1'b0;
            r_dram_addr   <= {AW{1'b0}};
            r_dram_bsel   <= 2'b00;
            r_dram_wrdata <= 16'h0000;
            r_dram_rfsh   <= 1'b0;
        end else if (slot) begin
            case (w_owner)
                OWN_VID: begin
                    r_dram_req    <= 1'b1;
                    r_dram_rnw    <= 1'b1;
                    r_dram_addr   <= video_addr;
                    r_dram_bsel   <= 2'b11;
                    r_dram_wrdata <= 16'h0000;
                    r_dram_rfsh   <= 1'b0;
                end
                OWN_CPU: begin
                    r_dram_req    <= 1'b1;
                    r_dram_rnw    <= cpu_rnw;
                    r_dram_addr   <= cpu_addr;
                    r_dram_bsel   <= cpu_rnw ? 2'b11 : (cpu_wrbsel ? 2'b10 : 2'b01);
                    r_dram_wrdata <= {cpu_wrdata, cpu_wrdata};
                    r_dram_rfsh   <= 1'b0;
                end
                OWN_DMA: begin
                    r_dram_req    <= 1'b1;
                    r_dram_rnw    <= dma_rnw;
                    r_dram_addr   <= dma_addr;
                    r_dram_bsel   <= dma_bsel;
                    r_dram_wrdata <= dma_wrdata;
                    r_dram_rfsh   <= 1'b0;
                end
                OWN_RFSH: begin
                    r_dram_req    <= 1'b0;
                    r_dram_rnw    <= 1'b0;
                    r_dram_addr   <= {AW{1'b0}};
                    r_dram_bsel   <= 2'b00;
                    r_dram_wrdata <= 16'h0000;
                    r_dram_rfsh   <= 1'b1;
                end
                default: begin
                    r_dram_req    <= 1'b0;
                    r_dram_rnw    <= 1'b0;
                    r_dram_addr   <= {AW{1'b0}};
                    r_dram_bsel   <= 2'b00;
                    r_dram_wrdata <= 16'h0000;
                    r_dram_rfsh   <= 1'b0;
                end
            endcase
        end
    end

    // One-clk grant pulses following the decision edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_video_next <= 1'b0;
            r_cpu_next   <= 1'b0;
            r_dma_next   <= 1'b0;
        end else begin
            r_video_next <= slot & (w_owner == OWN_VID);
            r_cpu_next   <= slot & (w_owner == OWN_CPU);
            r_dma_next   <= slot & (w_owner == OWN_DMA);
        end
    end

    // Read return: capture data and strobe the owner at the head of the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data      <= 16'h0000;
            r_video_strobe <= 1'b0;
            r_cpu_strobe   <= 1'b0;
            r_dma_strobe   <= 1'b0;
        end else begin
            r_video_strobe <= w_pop & (w_pop_tag == TAG_VID);
            r_cpu_strobe   <= w_pop & (w_pop_tag == TAG_CPU);
            r_dma_strobe   <= w_pop & (w_pop_tag == TAG_DMA);
            if (w_pop) begin
                r_rd_data <= rddata;
            end
        end
    end

    // Sticky flag for read data arriving with nobody waiting for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sched_err <= 1'b0;
        end else if (rrdy & w_q_empty) begin
            r_sched_err <= 1'b1;
        end
    end

    assign dram_req     = r_dram_req;
    assign dram_rnw     = r_dram_rnw;
    assign dram_addr    = r_dram_addr;
    assign dram_bsel    = r_dram_bsel;
    assign dram_wrdata  = r_dram_wrdata;
    assign dram_rfsh    = r_dram_rfsh;
    assign video_next   = r_video_next;
    assign cpu_next     = r_cpu_next;
    assign dma_next     = r_dma_next;
    assign video_strobe = r_video_strobe;
    assign cpu_strobe   = r_cpu_strobe;
    assign dma_strobe   = r_dma_strobe;
    assign rd_data      = r_rd_data;
    assign sched_err    = r_sched_err;
    assign cpu_stall    = cpu_req & ~r_cpu_next;

endmodule

// File: tb/tb_dram_slot_sched.sv
// Directed bench for dram_slot_sched with a short refresh interval.
module tb_dram_slot_sched;

    localparam int AW = 21;
    localparam logic [4:0] P_VID  = 5'b10001;
    localparam logic [4:0] P_CPU  = 5'b01001;
    localparam logic [4:0] P_DMA  = 5'b00101;
    localparam logic [4:0] P_RFSH = 5'b00010;
    localparam logic [4:0] P_IDLE = 5'b00000;

    logic          clk = 1'b0;
    logic          rst, slot, rrdy;
    logic [15:0]   rddata;
    logic          dram_req, dram_rnw, dram_rfsh;
    logic [AW-1:0] dram_addr;
    logic [1:0]    dram_bsel;
    logic [15:0]   dram_wrdata;
    logic          video_go;
    logic [1:0]    video_bw;
    logic [AW-1:0] video_addr;
    logic          video_next, video_strobe;
    logic          cpu_req, cpu_rnw, cpu_wrbsel;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wrdata;
    logic          cpu_next, cpu_strobe, cpu_stall;
    logic          dma_req, dma_rnw;
    logic [AW-1:0] dma_addr;
    logic [1:0]    dma_bsel;
    logic [15:0]   dma_wrdata;
    logic          dma_next, dma_strobe;
    logic [15:0]   rd_data;
    logic          sched_err;

    logic [4:0]    own;
    logic [2:0]    stb;
    int            n_vec = 0;
    int            n_err = 0;

    assign own = {video_next, cpu_next, dma_next, dram_rfsh, dram_req};
    assign stb = {video_strobe, cpu_strobe, dma_strobe};

    always #5 clk = ~clk;

    dram_slot_sched #(
        .AW(AW), .REFRESH_SLOTS(4), .RFSH_MAX(4), .RDQ_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .slot(slot), .rrdy(rrdy), .rddata(rddata),
        .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr),
        .dram_bsel(dram_bsel), .dram_wrdata(dram_wrdata), .dram_rfsh(dram_rfsh),
        .video_go(video_go), .video_bw(video_bw), .video_addr(video_addr),
        .video_next(video_next), .video_strobe(video_strobe),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
        .cpu_wrbsel(cpu_wrbsel), .cpu_wrdata(cpu_wrdata), .cpu_next(cpu_next),
        .cpu_strobe(cpu_strobe), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr),
        .dma_bsel(dma_bsel), .dma_wrdata(dma_wrdata), .dma_next(dma_next),
        .dma_strobe(dma_strobe), .rd_data(rd_data), .sched_err(sched_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_slot();
        slot = 1'b1;
        tick(1);
        slot = 1'b0;
    endtask

    task automatic do_rrdy(input logic [15:0] d);
        rrdy   = 1'b1;
        rddata = d;
        tick(1);
        rrdy   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; slot = 1'b0; rrdy = 1'b0; rddata = 16'h0000;
        video_go = 1'b0; video_bw = 2'b00; video_addr = 21'h0ABCD;
        cpu_req = 1'b0; cpu_rnw = 1'b1; cpu_addr = 21'h01111;
        cpu_wrbsel = 1'b0; cpu_wrdata = 8'h00;
        dma_req = 1'b0; dma_rnw = 1'b1; dma_addr = 21'h12222;
        dma_bsel = 2'b11; dma_wrdata = 16'h0000;
        tick(2);
        rst = 1'b0;
        tick(1);

        // 1: reset in the middle of traffic
        cpu_req = 1'b1; cpu_rnw = 1'b1;
        do_slot();
        chk("t1_own_rd", own, P_CPU);
        chk("t1_rd_enc", {dram_rnw, dram_bsel}, 3'b111);
        tick(1);
        do_rrdy(16'h1234);
        chk("t1_stb", stb, 3'b010);
        chk("t1_rdata", rd_data, 16'h1234);
        cpu_rnw = 1'b0; cpu_wrbsel = 1'b0; cpu_wrdata = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            do_slot();
            chk($sformatf("t1_own_wr%0d", i), own, P_CPU);
            chk($sformatf("t1_wr_enc%0d", i), {dram_rnw, dram_bsel, dram_wrdata}, {1'b0, 2'b01, 16'h3C3C});
            tick(1);
        end
        cpu_rnw = 1'b1;
        do_slot();
        chk("t1_own_rd2", own, P_CPU);
        chk("t1_credit_pre", dut.r_credit, 3'd1);
        chk("t1_qcnt_pre", dut.u_tag_fifo.r_count, 2'd1);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("t1_rst_dram", {dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata, dram_rfsh}, 64'd0);
        chk("t1_rst_ctl", {video_next, video_strobe, cpu_next, cpu_strobe, dma_next, dma_strobe, rd_data, sched_err}, 64'd0);
        chk("t1_rst_credit", dut.r_credit, 3'd0);
        chk("t1_rst_qcnt", dut.u_tag_fifo.r_count, 2'd0);
        do_slot();
        chk("t1_first_slot", own, P_CPU);
        cpu_req = 1'b0;
        tick(1);

        // 2: video bw=01 against continuous CPU and DMA reads
        do_reset();
        video_go = 1'b1; video_bw = 2'b01;
        cpu_req = 1'b1; cpu_rnw = 1'b1; dma_req = 1'b1; dma_rnw = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 2; k++) begin
                int s;
                s = 2 * p + k;
                do_slot();
                chk($sformatf("t2_own%0d", s), own, (s % 4 == 0) ? P_VID : P_CPU);
                chk($sformatf("t2_addr%0d", s), dram_addr, (s % 4 == 0) ? 21'h0ABCD : 21'h01111);
                tick(1);
            end
            do_rrdy(16'h1000 + 16'(2 * p));
            chk($sformatf("t2_stbA%0d", p), stb, (p % 2 == 0) ? 3'b100 : 3'b010);
            chk($sformatf("t2_rdA%0d", p), rd_data, 16'h1000 + 16'(2 * p));
            do_rrdy(16'h1001 + 16'(2 * p));
            chk($sformatf("t2_stbB%0d", p), stb, 3'b010);
        end
        cpu_req = 1'b0; dma_req = 1'b0; video_go = 1'b0;

        // 3: CPU byte writes
        do_reset();
        cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_wrbsel = 1'b1; cpu_wrdata = 8'hA5; cpu_addr = 21'h155AA;
        tick(1);
        chk("t3_stall_pre", cpu_stall, 1'b1);
        do_slot();
        chk("t3_own", own, P_CPU);
        chk("t3_enc", {dram_rnw, dram_bsel, dram_wrdata}, {1'b0, 2'b10, 16'hA5A5});
        chk("t3_addr", dram_addr, 21'h155AA);
        chk("t3_stall", cpu_stall, 1'b0);
        tick(1);
        cpu_wrbsel = 1'b0; cpu_wrdata = 8'h5A;
        do_slot();
        chk("t3_enc_lo", {dram_rnw, dram_bsel, dram_wrdata}, {1'b0, 2'b01, 16'h5A5A});
        cpu_req = 1'b0;
        tick(1);

        // 4: refresh credit build-up under full video load
        do_reset();
        video_go = 1'b1; video_bw = 2'b11;
        for (int s = 0; s < 16; s++) begin
            do_slot();
            chk($sformatf("t4_own%0d", s), own, P_VID);
            do_rrdy(16'h0100 + 16'(s));
            chk($sformatf("t4_stb%0d", s), stb, 3'b100);
        end
        chk("t4_credit16", dut.r_credit, 3'd4);
        do_slot();
        chk("t4_forced", own, P_RFSH);
        chk("t4_credit17", dut.r_credit, 3'd3);
        tick(1);
        video_go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [2:0] exp_cr [4];
            exp_cr = '{3'd2, 3'd1, 3'd1, 3'd0};
            do_slot();
            chk($sformatf("t4_opp%0d", i), own, P_RFSH);
            chk($sformatf("t4_cr%0d", i), dut.r_credit, exp_cr[i]);
            tick(1);
        end
        do_slot();
        chk("t4_idle", own, P_IDLE);
        tick(1);

        // 5: full tag queue blocks reads, a write takes the slot
        do_reset();
        video_go = 1'b1; video_bw = 2'b10;
        do_slot();
        chk("t5_own0", own, P_VID);
        tick(1);
        cpu_req = 1'b1; cpu_rnw = 1'b1;
        do_slot();
        chk("t5_own1", own, P_CPU);
        chk("t5_qcnt2", dut.u_tag_fifo.r_count, 2'd2);
        tick(1);
        dma_req = 1'b1; dma_rnw = 1'b0; dma_bsel = 2'b10; dma_wrdata = 16'hBEEF; dma_addr = 21'h1F00F;
        do_slot();
        chk("t5_own2", own, P_DMA);
        chk("t5_dma_enc", {dram_rnw, dram_bsel, dram_wrdata}, {1'b0, 2'b10, 16'hBEEF});
        chk("t5_dma_addr", dram_addr, 21'h1F00F);
        tick(1);
        dma_req = 1'b0;
        do_slot();
        chk("t5_own3", own, P_IDLE);
        tick(1);
        do_rrdy(16'h5A5A);
        chk("t5_stb_vid", stb, 3'b100);
        chk("t5_qcnt1", dut.u_tag_fifo.r_count, 2'd1);
        rrdy = 1'b1; rddata = 16'h6B6B; slot = 1'b1;
        tick(1);
        rrdy = 1'b0; slot = 1'b0;
        chk("t5_own4", own, P_VID);
        chk("t5_stb_cpu", stb, 3'b010);
        chk("t5_rd_cpu", rd_data, 16'h6B6B);
        chk("t5_qcnt_same", dut.u_tag_fifo.r_count, 2'd1);
        cpu_req = 1'b0; video_go = 1'b0;
        tick(1);

        // 6: stray read data sets the sticky error
        do_reset();
        do_rrdy(16'hDEAD);
        chk("t6_err", sched_err, 1'b1);
        chk("t6_stb", stb, 3'b000);
        chk("t6_rd", rd_data, 16'h0000);
        cpu_req = 1'b1; cpu_rnw = 1'b0;
        do_slot();
        cpu_req = 1'b0;
        tick(3);
        chk("t6_err_hold", sched_err, 1'b1);
        do_reset();
        chk("t6_err_clr", sched_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
